// File: rtl/page_responder.sv
// Page mover between a source/sink FIFO pair and a paged word store.
// Define PAGE_RESPONDER_CHECKSUM_EN to add the page_sum output.
module page_responder #(
    parameter int PAGE_LOG2 = 9,
    parameter int ROWS_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_pagewrite,
    input  logic        cmd_pageread,
    input  logic [14:0] rowaddr_in,
    output logic        cmd_ack,
    output logic        cmd_done,
    output logic        fifo_read,
    input  logic [15:0] fifo_din,
    output logic        fifo_write,
    output logic [15:0] fifo_dout,
    output logic        busy
`ifdef PAGE_RESPONDER_CHECKSUM_EN
    ,
    output logic [15:0] page_sum
`endif
);

    localparam int AW = ROWS_LOG2 + PAGE_LOG2;
    localparam logic [PAGE_LOG2:0] LAST = {1'b0, {PAGE_LOG2{1'b1}}};
    localparam logic [PAGE_LOG2:0] ONE  = 1;

    typedef enum logic [2:0] {IDLE, WACK, WRITE, READ, DONE} state_t;

    state_t               state;
    logic [ROWS_LOG2-1:0] row;
    logic                 is_write;
    logic [PAGE_LOG2:0]   cnt;
    logic                 rd_en;
    logic                 wr_valid;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        issue_addr;
    logic [15:0]          mem [0:(2**AW)-1];
    logic                 unused_bits;

    assign issue_addr  = {row, cnt[PAGE_LOG2-1:0]};
    assign unused_bits = ^{rowaddr_in[14:ROWS_LOG2], cnt[PAGE_LOG2]};

    // Issue side: the strobe drops one cycle before the pipeline drains, so a
    // low strobe while still in WRITE/READ marks the final data cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            is_write  <= 1'b0;
            cnt       <= '0;
            cmd_ack   <= 1'b0;
            cmd_done  <= 1'b0;
            fifo_read <= 1'b0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_ack  <= 1'b0;
            cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_pagewrite || cmd_pageread) begin
                        row      <= rowaddr_in[ROWS_LOG2-1:0];
                        is_write <= cmd_pagewrite;
                        cmd_ack  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WACK;
                    end
                end
                WACK: begin
                    cnt <= '0;
                    if (is_write) begin
                        fifo_read <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        rd_en <= 1'b1;
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (fifo_read) begin
                        if (cnt == LAST) begin
                            fifo_read <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end else begin
                        cmd_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        if (cnt == LAST) begin
                            rd_en <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end else begin
                        cmd_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            fifo_write <= 1'b0;
            fifo_dout  <= '0;
        end else begin
            wr_valid   <= fifo_read;
            wr_addr    <= issue_addr;
            fifo_write <= rd_en;
            if (rd_en) begin
                fifo_dout <= mem[issue_addr];
            end
        end
    end

    // Store contents survive reset; clearing wr_valid is what aborts a write.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            mem[wr_addr] <= fifo_din;
        end
    end

`ifdef PAGE_RESPONDER_CHECKSUM_EN
    logic [15:0] sum_acc;
    logic [15:0] sum_next;
    logic        last_data;

    assign last_data = ((state == WRITE) && !fifo_read) || ((state == READ) && !rd_en);

    always_comb begin
        sum_next = sum_acc;
        if (wr_valid) begin
            sum_next = sum_acc + fifo_din;
        end else if (fifo_write) begin
            sum_next = sum_acc + fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_acc  <= '0;
            page_sum <= '0;
        end else if (state == WACK) begin
            sum_acc <= '0;
        end else begin
            sum_acc <= sum_next;
            if (last_data) begin
                page_sum <= sum_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_page_responder.sv
// Scoreboard bench for page_responder: source FIFO model, expected-read queue.
module tb_page_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_pagewrite;
    logic        cmd_pageread;
    logic [14:0] rowaddr_in;
    logic        cmd_ack;
    logic        cmd_done;
    logic        fifo_read;
    logic [15:0] fifo_din;
    logic        fifo_write;
    logic [15:0] fifo_dout;
    logic        busy;
`ifdef PAGE_RESPONDER_CHECKSUM_EN
    logic [15:0] page_sum;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] model [0:2047];
    logic [15:0] exp_sum;
    logic [15:0] last_dout;

    page_responder dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_pagewrite(cmd_pagewrite),
        .cmd_pageread (cmd_pageread),
        .rowaddr_in   (rowaddr_in),
        .cmd_ack      (cmd_ack),
        .cmd_done     (cmd_done),
        .fifo_read    (fifo_read),
        .fifo_din     (fifo_din),
        .fifo_write   (fifo_write),
        .fifo_dout    (fifo_dout),
        .busy         (busy)
`ifdef PAGE_RESPONDER_CHECKSUM_EN
        ,
        .page_sum     (page_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] genWord(input int pat, input int i);
        case (pat)
            0:       return 16'(i);
            1:       return 16'(i * 3 + 7);
            2:       return 16'hA5A5;
            3:       return 16'(16'h2000 + i);
            4:       return 16'(16'h7000 + i);
            5:       return 16'h0100;
            default: return 16'h0001;
        endcase
    endfunction

    // Source FIFO: a word popped on fifo_read is presented during the next cycle.
    always @(posedge clk) begin : src_fifo
        logic [15:0] w;
        if (fifo_read === 1'b1 && reset === 1'b0) begin
            w = (src_q.size() > 0) ? src_q.pop_front() : 16'h0000;
            #1 fifo_din = w;
        end
    end

    // Sink side: every pushed word is compared against the scoreboard queue.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            last_dout = 16'h0000;
        end else if (fifo_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("write_without_expect", fifo_write, 0);
            end else begin
                last_dout = exp_q.pop_front();
                checkOutput("rd_data", fifo_dout, last_dout);
            end
        end else begin
            checkOutput("dout_hold", fifo_dout, last_dout);
        end
    end

    task automatic loadSource(input int pat);
        src_q.delete();
        exp_sum = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            src_q.push_back(genWord(pat, i));
            exp_sum = exp_sum + genWord(pat, i);
        end
    endtask

    task automatic commitModel(input logic [14:0] row, input int pat, input int upto);
        for (int i = 0; i < upto; i++) begin
            model[int'(row[1:0]) * 512 + i] = genWord(pat, i);
        end
    endtask

    task automatic expectRead(input logic [14:0] row);
        exp_sum = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(model[int'(row[1:0]) * 512 + i]);
            exp_sum = exp_sum + model[int'(row[1:0]) * 512 + i];
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ack"},   cmd_ack, 0);
        checkOutput({tag, "_done"},  cmd_done, 0);
        checkOutput({tag, "_fread"}, fifo_read, 0);
        checkOutput({tag, "_fwrite"}, fifo_write, 0);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_dout"},  fifo_dout, 0);
`ifdef PAGE_RESPONDER_CHECKSUM_EN
        checkOutput({tag, "_sum"},   page_sum, 0);
`endif
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [14:0] row,
                                 input bit hold_cmd, input int exp_ack_wait, input int abort_at);
        int w;
        int n_rd, n_wr, first_rd, last_rd, first_wr, last_wr, done_rel;
        logic busy_ok;
        @(negedge clk);
        cmd_pagewrite = wr;
        cmd_pageread  = rd;
        rowaddr_in    = row;
        w = 0;
        while (cmd_ack !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        checkOutput("ack_wait", w, exp_ack_wait);
        if (cmd_ack !== 1'b1) begin
            cmd_pagewrite = 1'b0;
            cmd_pageread  = 1'b0;
            return;
        end
        checkOutput("busy_T0", busy, 1);
        if (!hold_cmd) begin
            cmd_pagewrite = 1'b0;
            cmd_pageread  = 1'b0;
        end
        n_rd = 0; n_wr = 0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        done_rel = -1;
        busy_ok = 1'b1;
        for (int rel = 1; rel <= 600; rel++) begin
            @(negedge clk);
            if (abort_at != 0 && rel == abort_at) begin
                #1 reset = 1'b1;
                #1 checkResetOutputs("abort");
                src_q.delete();
                cmd_pagewrite = 1'b0;
                cmd_pageread  = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("done_in_abort", cmd_done, 0);
                end
                reset = 1'b0;
                return;
            end
            if (fifo_read === 1'b1) begin
                n_rd++;
                if (first_rd < 0) first_rd = rel;
                last_rd = rel;
            end
            if (fifo_write === 1'b1) begin
                n_wr++;
                if (first_wr < 0) first_wr = rel;
                last_wr = rel;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cmd_done === 1'b1) begin
                done_rel = rel;
                break;
            end
        end
        checkOutput("busy_T0_to_done", busy_ok, 1);
        checkOutput("done_latency", done_rel, 514);
        checkOutput("fifo_read_count", n_rd, wr ? 512 : 0);
        checkOutput("fifo_write_count", n_wr, wr ? 0 : 512);
        if (wr) begin
            checkOutput("fifo_read_first", first_rd, 1);
            checkOutput("fifo_read_last", last_rd, 512);
        end else begin
            checkOutput("fifo_write_first", first_wr, 2);
            checkOutput("fifo_write_last", last_wr, 513);
        end
`ifdef PAGE_RESPONDER_CHECKSUM_EN
        checkOutput("page_sum", page_sum, exp_sum);
`endif
        if (hold_cmd) begin
            cmd_pagewrite = 1'b0;
            @(negedge clk);
            checkOutput("busy_T515", busy, 0);
            checkOutput("ack_T515", cmd_ack, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        cmd_pagewrite = 1'b0;
        cmd_pageread  = 1'b0;
        rowaddr_in    = '0;
        fifo_din      = '0;
        last_dout     = '0;
        exp_sum       = '0;
        #1 checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Write row 1 with an ascending ramp, then read it back.
        loadSource(0);
        applyStimulus(1'b1, 1'b0, 15'd1, 1'b0, 1, 0);
        commitModel(15'd1, 0, 512);
        expectRead(15'd1);
        applyStimulus(1'b0, 1'b1, 15'd1, 1'b0, 1, 0);
        checkOutput("sb_empty_row1", exp_q.size(), 0);

        // Both commands together: write wins, held read starts right after.
        loadSource(1);
        applyStimulus(1'b1, 1'b1, 15'd3, 1'b1, 1, 0);
        commitModel(15'd3, 1, 512);
        expectRead(15'd3);
        applyStimulus(1'b0, 1'b1, 15'd3, 1'b0, 0, 0);
        checkOutput("sb_empty_row3", exp_q.size(), 0);

        // Row 5 aliases onto row 1.
        loadSource(2);
        applyStimulus(1'b1, 1'b0, 15'h0005, 1'b0, 1, 0);
        commitModel(15'h0005, 2, 512);
        expectRead(15'h0001);
        applyStimulus(1'b0, 1'b1, 15'h0001, 1'b0, 1, 0);
        checkOutput("sb_empty_alias", exp_q.size(), 0);

        // Reset in the middle of a write keeps only words stored so far.
        loadSource(3);
        applyStimulus(1'b1, 1'b0, 15'd2, 1'b0, 1, 0);
        commitModel(15'd2, 3, 512);
        loadSource(4);
        applyStimulus(1'b1, 1'b0, 15'd2, 1'b0, 1, 200);
        commitModel(15'd2, 4, 198);
        expectRead(15'd2);
        applyStimulus(1'b0, 1'b1, 15'd2, 1'b0, 1, 0);
        checkOutput("sb_empty_abort", exp_q.size(), 0);

        // Checksum patterns: wrap to zero, then 0x0200.
        loadSource(5);
        applyStimulus(1'b1, 1'b0, 15'd0, 1'b0, 1, 0);
        commitModel(15'd0, 5, 512);
        loadSource(6);
        applyStimulus(1'b1, 1'b0, 15'd0, 1'b0, 1, 0);
        commitModel(15'd0, 6, 512);
        expectRead(15'd0);
        applyStimulus(1'b0, 1'b1, 15'd0, 1'b0, 1, 0);
        checkOutput("sb_empty_row0", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
